// File: rtl/feature_window_buffer_if.sv
// Window output channel of feature_window_buffer: nine parallel lanes plus
// output coordinates over a valid/ready handshake.
interface feature_window_buffer_if #(
  parameter int DATA_W = 8,
  parameter int AW_W   = 4,
  parameter int AH_W   = 4
);
  logic                  win_valid;
  logic                  win_ready;
  logic [9*DATA_W-1:0]   win_data;
  logic [AW_W-1:0]       win_ox;
  logic [AH_W-1:0]       win_oy;

  modport master (output win_valid, win_data, win_ox, win_oy, input win_ready);
  modport slave  (input win_valid, win_data, win_ox, win_oy, output win_ready);
endinterface

// File: rtl/feature_window_buffer.sv
// Feature-map memory with one write port and an autonomous 3x3 window scan
// engine (stride 1/2, optional 1-pixel zero padding).
module feature_window_buffer #(
  parameter int DATA_W = 8,
  parameter int MAP_W  = 16,
  parameter int MAP_H  = 16,
  parameter int AW_W   = 4,
  parameter int AH_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [AW_W-1:0]   wr_x,
  input  logic [AH_W-1:0]   wr_y,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              cfg_stride,
  input  logic              cfg_pad,
  feature_window_buffer_if.master win,
  output logic              busy,
  output logic              done
);
  localparam int ADDR_W = $clog2(MAP_W * MAP_H);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t              state_q, state_d;
  logic                stride_q, stride_d, pad_q, pad_d;
  logic [AW_W-1:0]     ox_q, ox_d, last_ox;
  logic [AH_W-1:0]     oy_q, oy_d, last_oy;
  logic                busy_q, busy_d, done_q, done_d;
  logic [9*DATA_W-1:0] win_data_q, win_data_d, fetched;
  logic [DATA_W-1:0]   mem_q [MAP_W*MAP_H];

  logic signed [AW_W+1:0] x0;
  logic signed [AH_W+1:0] y0;
  int                     tx, ty;

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && int'(wr_x) < MAP_W && int'(wr_y) < MAP_H)
      mem_q[ADDR_W'(int'(wr_y) * MAP_W + int'(wr_x))] <= wr_data;
  end

  // Index of the last output column/row: (MAP + 2P - 3) / S.
  always_comb begin
    unique case ({stride_q, pad_q})
      2'b00:   begin last_ox = AW_W'(MAP_W - 3);       last_oy = AH_W'(MAP_H - 3);       end
      2'b01:   begin last_ox = AW_W'(MAP_W - 1);       last_oy = AH_W'(MAP_H - 1);       end
      2'b10:   begin last_ox = AW_W'((MAP_W - 3) / 2); last_oy = AH_W'((MAP_H - 3) / 2); end
      default: begin last_ox = AW_W'((MAP_W - 1) / 2); last_oy = AH_W'((MAP_H - 1) / 2); end
    endcase
  end

  always_comb begin
    x0 = (stride_q ? {1'b0, ox_q, 1'b0} : {2'b00, ox_q}) - (AW_W+2)'(pad_q);
    y0 = (stride_q ? {1'b0, oy_q, 1'b0} : {2'b00, oy_q}) - (AH_W+2)'(pad_q);
  end

  // Nine combinational taps; out-of-map taps read as zero.
  always_comb begin
    fetched = '0;
    tx      = 0;
    ty      = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        tx = int'(x0) + int'(j);
        ty = int'(y0) + int'(i);
        if (tx >= 0 && tx < MAP_W && ty >= 0 && ty < MAP_H)
          fetched[(i*3+j)*DATA_W +: DATA_W] = mem_q[ADDR_W'(ty * MAP_W + tx)];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      stride_q   <= 1'b0;
      pad_q      <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      win_data_q <= '0;
    end else begin
      state_q    <= state_d;
      stride_q   <= stride_d;
      pad_q      <= pad_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      win_data_q <= win_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stride_d   = stride_q;
    pad_d      = pad_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    win_data_d = win_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          stride_d = cfg_stride;
          pad_d    = cfg_pad;
          ox_d     = '0;
          oy_d     = '0;
          busy_d   = 1'b1;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        win_data_d = fetched;
        state_d    = HOLD;
      end
      HOLD: begin
        if (win.win_ready) begin
          if (ox_q == last_ox && oy_q == last_oy) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            if (ox_q == last_ox) begin
              ox_d = '0;
              oy_d = oy_q + AH_W'(1);
            end else begin
              ox_d = ox_q + AW_W'(1);
            end
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign win.win_valid = (state_q == HOLD);
  assign win.win_data  = win_data_q;
  assign win.win_ox    = ox_q;
  assign win.win_oy    = oy_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule
